// File: rtl/rk_pkg.sv
// Shared types and constants for the RK step sequencer.
package rk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        UPDATE,
        FINISH
    } rk_state_e;

    localparam logic [1:0] K1 = 2'd0;
    localparam logic [1:0] K2 = 2'd1;
    localparam logic [1:0] K3 = 2'd2;
    localparam logic [1:0] K4 = 2'd3;

    localparam logic SEL_Y0    = 1'b0;
    localparam logic SEL_YNEXT = 1'b1;

endpackage

// File: rtl/rk_wdog.sv
// Per-stage watchdog: counts EVAL cycles without a stage result and flags the terminal count.
module rk_wdog #(
    parameter int unsigned WDOG_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic kick_i,
    output logic expired_o
);

    localparam int unsigned CW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || kick_i) begin
            cnt_d = '0;
        end
    end

    // Expiry fires on the WDOG_CYC-th consecutive waiting cycle.
    assign expired_o = run_i && !kick_i && (cnt_q == CW'(WDOG_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rk_step_ctrl.sv
// RK4 step sequencer: drives the y0/y_next mux select and commits the integrator state.
// Optional stage watchdog is enabled with the RK_WDOG_EN macro.
module rk_step_ctrl
    import rk_pkg::*;
#(
    parameter int unsigned n        = 32,
    parameter int unsigned SW       = 16,
    parameter int unsigned WDOG_CYC = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [SW-1:0] STEPS,
    input  logic [n-1:0]  Y_MUX,
    input  logic          K_VALID,
    output logic          SEL,
    output logic [1:0]    STAGE,
    output logic [n-1:0]  Y_OUT,
    output logic [SW-1:0] STEP_CNT,
    output logic          Y_VALID,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    rk_state_e     state_q, state_d;
    logic [1:0]    stage_q, stage_d;
    logic [n-1:0]  y_out_q, y_out_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [SW-1:0] steps_q, steps_d;
    logic [SW-1:0] step_inc;
    logic          y_valid_q, y_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

`ifdef RK_WDOG_EN
    logic err_q, err_d;
    logic wdog_expired;

    rk_wdog #(
        .WDOG_CYC(WDOG_CYC)
    ) u_wdog (
        .clk_i    (CLK),
        .rst_i    (RST),
        .run_i    (state_q == EVAL),
        .kick_i   (K_VALID),
        .expired_o(wdog_expired)
    );
`endif

    assign step_inc = step_cnt_q + SW'(1);

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        y_out_d    = y_out_q;
        step_cnt_d = step_cnt_q;
        steps_d    = steps_q;
        busy_d     = busy_q;
        y_valid_d  = 1'b0;
        done_d     = 1'b0;
`ifdef RK_WDOG_EN
        err_d      = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                // busy_q still set here means this is the DONE cycle: drop BUSY, ignore START.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (START) begin
`ifdef RK_WDOG_EN
                    err_d = 1'b0;
`endif
                    if (STEPS == '0) begin
                        done_d = 1'b1;
                    end else begin
                        steps_d    = STEPS;
                        step_cnt_d = '0;
                        busy_d     = 1'b1;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                y_out_d = Y_MUX;
                stage_d = K1;
                state_d = EVAL;
            end
            EVAL: begin
`ifdef RK_WDOG_EN
                if (wdog_expired) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    stage_d = K1;
                    state_d = IDLE;
                end else
`endif
                if (K_VALID) begin
                    if (stage_q == K4) begin
                        state_d = UPDATE;
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end
            end
            UPDATE: begin
                y_out_d    = Y_MUX;
                step_cnt_d = step_inc;
                y_valid_d  = 1'b1;
                stage_d    = K1;
                state_d    = (step_inc == steps_q) ? FINISH : EVAL;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            stage_q    <= K1;
            y_out_q    <= '0;
            step_cnt_q <= '0;
            steps_q    <= '0;
            y_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            y_out_q    <= y_out_d;
            step_cnt_q <= step_cnt_d;
            steps_q    <= steps_d;
            y_valid_q  <= y_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef RK_WDOG_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign SEL      = ((state_q == EVAL) || (state_q == UPDATE)) ? SEL_YNEXT : SEL_Y0;
    assign STAGE    = stage_q;
    assign Y_OUT    = y_out_q;
    assign STEP_CNT = step_cnt_q;
    assign Y_VALID  = y_valid_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_rk_step_ctrl.sv
// Scoreboard bench for rk_step_ctrl: directed runs push expected Y_VALID/DONE events,
// a negedge monitor pops and compares them including their cycle of arrival.
module tb_rk_step_ctrl;

    localparam int unsigned N  = 32;
    localparam int unsigned SW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [SW-1:0] STEPS;
    logic [N-1:0]  Y_MUX;
    logic          K_VALID;
    logic          SEL;
    logic [1:0]    STAGE;
    logic [N-1:0]  Y_OUT;
    logic [SW-1:0] STEP_CNT;
    logic          Y_VALID;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    logic [N-1:0]  y0;
    logic [N-1:0]  ynext_base;

    rk_step_ctrl #(
        .n       (N),
        .SW      (SW),
        .WDOG_CYC(8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .STEPS   (STEPS),
        .Y_MUX   (Y_MUX),
        .K_VALID (K_VALID),
        .SEL     (SEL),
        .STAGE   (STAGE),
        .Y_OUT   (Y_OUT),
        .STEP_CNT(STEP_CNT),
        .Y_VALID (Y_VALID),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    // Mux model: y_next differs per step so each commit is distinguishable.
    assign Y_MUX = SEL ? (ynext_base + N'(STEP_CNT)) : y0;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit            is_done;
        int            cyc;
        logic [N-1:0]  y;
        logic [SW-1:0] cnt;
        logic          err;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input bit d, input int c, input logic [N-1:0] y,
                        input logic [SW-1:0] cnt, input logic err, input logic busy);
        exp_t e;
        e.is_done = d;
        e.cyc     = c;
        e.y       = y;
        e.cnt     = cnt;
        e.err     = err;
        e.busy    = busy;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input bit is_done);
        exp_t e;
        if (exp_q.size() == 0) begin
            if (is_done) chk("unexpected_done", 32'(DONE), 32'd0);
            else         chk("unexpected_y_valid", 32'(Y_VALID), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(is_done ? "event_kind_done" : "event_kind_y_valid", 32'(is_done), 32'(e.is_done));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            chk("event_y_out", Y_OUT, e.y);
            chk("event_step_cnt", 32'(STEP_CNT), 32'(e.cnt));
            if (is_done) begin
                chk("done_err", 32'(ERR), 32'(e.err));
                chk("done_busy", 32'(BUSY), 32'(e.busy));
            end
        end
    endtask

    always @(negedge CLK) begin
        if (Y_VALID === 1'b1) mon_event(1'b0);
        if (DONE === 1'b1)    mon_event(1'b1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_start(input logic [SW-1:0] s);
        START = 1'b1;
        STEPS = s;
        tick();
        START = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_sel", 32'(SEL), 32'd0);
        chk("rst_stage", 32'(STAGE), 32'd0);
        chk("rst_y_out", Y_OUT, 32'd0);
        chk("rst_step_cnt", 32'(STEP_CNT), 32'd0);
        chk("rst_y_valid", 32'(Y_VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
    endtask

    // Called in the LOAD cycle; drives n_run steps of a run programmed for n_total.
    task automatic run_steps(input int n_run, input int n_total, input int gap, input bit inj);
        int t;
        chk("sel_load", 32'(SEL), 32'd0);
        tick();
        chk("sel_eval", 32'(SEL), 32'd1);
        chk("y_out_y0", Y_OUT, y0);
        for (int step = 0; step < n_run; step++) begin
            for (int k = 0; k < 4; k++) begin
                for (int g = 0; g < gap; g++) begin
                    K_VALID = 1'b0;
                    if (inj && step == 0 && k == 0 && g == 0) begin
                        START = 1'b1;
                        STEPS = 16'd7;
                    end
                    tick();
                    START = 1'b0;
                end
                chk("stage", 32'(STAGE), 32'(k));
                chk("busy_eval", 32'(BUSY), 32'd1);
                K_VALID = 1'b1;
                t = cyc;
                tick();
            end
            push(1'b0, t + 2, ynext_base + N'(step), SW'(step + 1), 1'b0, 1'b1);
            if (step == n_total - 1) begin
                push(1'b1, t + 3, ynext_base + N'(step), SW'(step + 1), 1'b0, 1'b1);
            end
            K_VALID = (gap == 0);
            tick();
            K_VALID = 1'b0;
            if (step == n_total - 1) chk("sel_finish", 32'(SEL), 32'd0);
            else                     chk("sel_next_eval", 32'(SEL), 32'd1);
        end
    endtask

    task automatic finish_wait(input bit start_at_done);
        int i;
        tick();
        if (start_at_done) begin
            START = 1'b1;
            STEPS = 16'd1;
        end
        tick();
        START = 1'b0;
        i = 0;
        while (BUSY !== 1'b0 && i < 10) begin
            tick();
            i++;
        end
        chk("busy_released", 32'(BUSY), 32'd0);
        repeat (3) tick();
        chk("busy_stays_low", 32'(BUSY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        RST        = 1'b1;
        START      = 1'b0;
        K_VALID    = 1'b0;
        STEPS      = '0;
        y0         = '0;
        ynext_base = '0;
        repeat (2) tick();
        check_reset_values();
        RST = 1'b0;
        tick();

        // Single step, K_VALID every third cycle.
        y0         = 32'h10;
        ynext_base = 32'h20;
        issue_start(16'd1);
        run_steps(1, 1, 2, 1'b0);
        finish_wait(1'b0);
        chk("t1_y_out", Y_OUT, 32'h20);
        chk("t1_step_cnt", 32'(STEP_CNT), 32'd1);

        // Three steps, K_VALID held high; START coinciding with DONE must be ignored.
        y0         = 32'h100;
        ynext_base = 32'h200;
        issue_start(16'd3);
        run_steps(3, 3, 0, 1'b0);
        finish_wait(1'b1);
        chk("t2_y_out", Y_OUT, 32'h202);
        chk("t2_step_cnt", 32'(STEP_CNT), 32'd3);

        // Zero steps: DONE next cycle, nothing else moves.
        push(1'b1, cyc + 1, 32'h202, 16'd3, 1'b0, 1'b0);
        issue_start(16'd0);
        chk("t3_busy", 32'(BUSY), 32'd0);
        tick();
        chk("t3_busy_after", 32'(BUSY), 32'd0);
        chk("t3_y_out", Y_OUT, 32'h202);
        chk("t3_step_cnt", 32'(STEP_CNT), 32'd3);

        // START while busy is ignored.
        y0         = 32'h30;
        ynext_base = 32'h40;
        issue_start(16'd2);
        run_steps(2, 2, 2, 1'b1);
        finish_wait(1'b0);
        chk("t5_y_out", Y_OUT, 32'h41);
        chk("t5_step_cnt", 32'(STEP_CNT), 32'd2);

        // Reset during EVAL of step 2 of 4, then a clean run.
        y0         = 32'h50;
        ynext_base = 32'h60;
        issue_start(16'd4);
        run_steps(1, 4, 0, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset_values();
        repeat (5) tick();
        chk("t4_idle_busy", 32'(BUSY), 32'd0);
        y0         = 32'h70;
        ynext_base = 32'h80;
        issue_start(16'd1);
        run_steps(1, 1, 1, 1'b0);
        finish_wait(1'b0);
        chk("t4_y_out", Y_OUT, 32'h80);
        chk("t4_step_cnt", 32'(STEP_CNT), 32'd1);

`ifdef RK_WDOG_EN
        // Stall in stage k3 of step 2: abort after 8 waiting cycles.
        begin
            int p;
            int i;
            y0         = 32'h90;
            ynext_base = 32'hA0;
            issue_start(16'd2);
            run_steps(1, 2, 0, 1'b0);
            K_VALID = 1'b1;
            tick();
            chk("t6_stage1", 32'(STAGE), 32'd1);
            p = cyc;
            tick();
            K_VALID = 1'b0;
            push(1'b1, p + 9, 32'hA0, 16'd1, 1'b1, 1'b1);
            chk("t6_stage2", 32'(STAGE), 32'd2);
            i = 0;
            while (BUSY !== 1'b0 && i < 20) begin
                tick();
                i++;
            end
            chk("t6_busy_released", 32'(BUSY), 32'd0);
            chk("t6_err_sticky", 32'(ERR), 32'd1);
            chk("t6_y_out_kept", Y_OUT, 32'hA0);
            chk("t6_step_cnt", 32'(STEP_CNT), 32'd1);
            y0         = 32'hB0;
            ynext_base = 32'hC0;
            issue_start(16'd1);
            chk("t6_err_cleared", 32'(ERR), 32'd0);
            run_steps(1, 1, 0, 1'b0);
            finish_wait(1'b0);
            chk("t6_recover_y_out", Y_OUT, 32'hC0);
        end
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rk_step_ctrl.md
Name: rk_step_ctrl

Overview:
- Sequencer that drives the select of the 2:1 state mux (IN_0 = initial y0, IN_1 = computed y_next) and consumes the mux output into the integrator state register.
- Walks each Runge-Kutta step through stages k1..k4, waits for the derivative datapath to report each stage result, then commits y_next.
- Repeats for a programmed number of steps, with a start/done handshake to the host.

Parameters:
- n, 32, data width of the mux output and the state register.
- SW, 16, width of the step count.
- WDOG_CYC, 255, cycle budget per stage; used only when RK_WDOG_EN is defined.

Ports:
- CLK  in  1  clock; all logic on its rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  single-cycle start request; ignored while BUSY=1.
- STEPS  in  SW  number of RK steps; sampled when START is accepted.
- Y_MUX  in  n  output of the downstream-fed 2:1 mux.
- K_VALID  in  1  single-cycle pulse: the current stage result is ready.
- SEL  out  1  mux select: 0 selects y0, 1 selects y_next.
- STAGE  out  2  current stage, 0..3 = k1..k4.
- Y_OUT  out  n  registered integrator state.
- STEP_CNT  out  SW  number of completed steps.
- Y_VALID  out  1  one-cycle pulse when Y_OUT receives a new step result.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  watchdog abort flag; tied 0 without RK_WDOG_EN.

Behaviour:
- Interface fact: one clock (CLK); RST is synchronous and active-high.
- Reset values: state=IDLE, SEL=0, STAGE=0, Y_OUT=0, STEP_CNT=0, Y_VALID=0, BUSY=0, DONE=0, ERR=0, latched steps=0.
- RST has priority over all other inputs. Asserting it mid-operation aborts to IDLE with the reset values above and produces no DONE.
- SEL, STAGE and BUSY are Moore decodes of registered state (no input-to-output combinational path).
- SEL=1 only in EVAL and UPDATE.
- States:
  - IDLE: BUSY=0.
    - START with STEPS=0: DONE=1 next cycle; Y_OUT and STEP_CNT unchanged; stay in IDLE.
    - START with STEPS!=0: latch STEPS, clear STEP_CNT, go to LOAD.
  - LOAD: SEL=0; Y_OUT<=Y_MUX (y0); STAGE<=0; go to EVAL. Duration is 1 cycle.
  - EVAL: hold until K_VALID.
    - On K_VALID with STAGE<3: STAGE<=STAGE+1.
    - On K_VALID with STAGE=3: go to UPDATE.
    - K_VALID outside EVAL is ignored.
  - UPDATE: SEL=1; Y_OUT<=Y_MUX (y_next); STEP_CNT<=STEP_CNT+1; Y_VALID=1 in the following cycle; STAGE<=0.
    - If STEP_CNT+1 equals the latched steps: go to FINISH.
    - Otherwise: go to EVAL.
  - FINISH: DONE=1 for one cycle; go to IDLE. Y_OUT holds its final value until the next LOAD or RST.
- Latency:
  - START to first EVAL cycle: 2 cycles.
  - Last K_VALID to Y_VALID: 2 cycles.
  - Last K_VALID to DONE: 3 cycles.
- STEP_CNT wraps at 2^SW-1 only if STEPS=0 were allowed through; this cannot occur, so no wrap logic is needed.
- A START arriving together with the DONE pulse is ignored, because BUSY is still 1 in that cycle.

Optional Feature:
- Macro: RK_WDOG_EN.
- Defined:
  - A per-stage counter clears on entry to EVAL and on each K_VALID.
  - If it reaches WDOG_CYC without a K_VALID: go to IDLE, set ERR=1 (sticky until the next accepted START or RST), assert DONE for one cycle, and keep Y_OUT.
- Undefined: no counter; ERR is constant 0; EVAL waits indefinitely.

Decomposition:
- Package rk_pkg holds:
  - the state enum (IDLE, LOAD, EVAL, UPDATE, FINISH);
  - stage constants K1=0 .. K4=3;
  - mux select constants SEL_Y0=0, SEL_YNEXT=1.
- Sub-module rk_wdog holds the stage watchdog counter with terminal flag. It is instantiated only under RK_WDOG_EN.

Test Plan:
1. Basic run: Y_MUX=0x00000010 in LOAD and 0x00000020 in UPDATE, STEPS=1, K_VALID every 3rd cycle, 4 pulses -> SEL 0 then 1; Y_OUT=0x10 then 0x20; one Y_VALID; STEP_CNT=1; DONE 3 cycles after the 4th K_VALID.
2. Multi-step: STEPS=3, K_VALID held high continuously -> STAGE sequence 0,1,2,3 per step; three Y_VALID pulses spaced 5 cycles apart; STEP_CNT=3; a single DONE.
3. Zero steps: START with STEPS=0 -> DONE next cycle; BUSY stays 0; Y_OUT and STEP_CNT unchanged.
4. Reset mid-operation: RST during EVAL of step 2 of 4 -> next cycle all outputs at reset values; no DONE; a following START with STEPS=1 completes normally.
5. START ignored while busy: second START with STEPS=7 during EVAL -> run still ends after the original STEPS=2; STEP_CNT=2.
6. RK_WDOG_EN defined, WDOG_CYC=8: no K_VALID in stage 2 -> ERR=1 and DONE after 8 cycles; state returns to IDLE; Y_OUT keeps the last committed value.
